// File: rtl/tictac_pkg.sv
// Shared types for the tic-tac-toe referee: cell codes, FSM states and the
// opponent helper used when handing the turn over.
package tictac_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    X     = 2'b01,
    O     = 2'b10
  } cell_t;

  typedef enum logic [1:0] {
    PLAY,
    CHECK,
    OVER
  } state_t;

  function automatic cell_t opponent(input cell_t c);
    return (c == X) ? O : X;
  endfunction

endpackage

// File: rtl/tictac_line_check.sv
// Combinational detector: is any row, column or diagonal of the board
// completely owned by the given player?
module tictac_line_check
  import tictac_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [2*N*N-1:0] board,
  input  cell_t            player,
  output logic             found
);

  logic lineOk;

  always_comb begin
    found  = 1'b0;
    lineOk = 1'b0;
    for (int r = 0; r < N; r++) begin
      lineOk = 1'b1;
      for (int c = 0; c < N; c++)
        if (board[2*(r*N+c) +: 2] != player) lineOk = 1'b0;
      found = found | lineOk;
    end
    for (int c = 0; c < N; c++) begin
      lineOk = 1'b1;
      for (int r = 0; r < N; r++)
        if (board[2*(r*N+c) +: 2] != player) lineOk = 1'b0;
      found = found | lineOk;
    end
    lineOk = 1'b1;
    for (int d = 0; d < N; d++)
      if (board[2*(d*N+d) +: 2] != player) lineOk = 1'b0;
    found = found | lineOk;
    lineOk = 1'b1;
    for (int d = 0; d < N; d++)
      if (board[2*(d*N+(N-1-d)) +: 2] != player) lineOk = 1'b0;
    found = found | lineOk;
  end

endmodule

// File: rtl/tictac_referee.sv
// Referee for an N x N tic-tac-toe game: validates moves, records the board,
// and declares a win or draw one cycle after each accepted move.
module tictac_referee
  import tictac_pkg::*;
#(
  parameter int         N     = 3,
  parameter logic [1:0] FIRST = 2'b01
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        newGame,
  input  logic [$clog2(N*N)-1:0]      move,
  input  logic                        moveValid,
  output logic                        moveReady,
  output logic [1:0]                  turn,
  output logic [2*N*N-1:0]            board,
  output logic [$clog2(N*N+1)-1:0]    moveCount,
  output logic                        illegal,
  output logic                        win,
  output logic [1:0]                  winner,
  output logic                        draw
);

  localparam int CELLS = N * N;
  localparam int IW    = $clog2(CELLS);
  localparam int CW    = $clog2(CELLS + 1);

  state_t state;
  logic   inRange;
  logic   occupied;
  logic   lineFound;

  assign moveReady = (state == PLAY) && !newGame && !reset;

  always_comb begin
    inRange  = 1'b0;
    occupied = 1'b0;
    for (int i = 0; i < CELLS; i++) begin
      if (move == IW'(i)) begin
        inRange  = 1'b1;
        occupied = (board[2*i +: 2] != EMPTY);
      end
    end
  end

  tictac_line_check #(.N(N)) lineCheck (
    .board (board),
    .player(cell_t'(turn)),
    .found (lineFound)
  );

  // During CHECK the turn register still holds the last mover's code.
  always_ff @(posedge clock) begin
    if (reset || newGame) begin
      state     <= PLAY;
      board     <= '0;
      moveCount <= '0;
      turn      <= FIRST;
      illegal   <= 1'b0;
      win       <= 1'b0;
      winner    <= EMPTY;
      draw      <= 1'b0;
    end else begin
      illegal <= 1'b0;
      case (state)
        PLAY: begin
          if (moveValid) begin
            if (inRange && !occupied) begin
              for (int i = 0; i < CELLS; i++)
                if (move == IW'(i)) board[2*i +: 2] <= turn;
              moveCount <= moveCount + CW'(1);
              state     <= CHECK;
            end else begin
              illegal <= 1'b1;
            end
          end
        end
        CHECK: begin
          if (lineFound) begin
            state  <= OVER;
            win    <= 1'b1;
            winner <= turn;
          end else if (moveCount == CW'(CELLS)) begin
            state <= OVER;
            draw  <= 1'b1;
          end else begin
            state <= PLAY;
            turn  <= opponent(cell_t'(turn));
          end
        end
        OVER: ;
        default: state <= PLAY;
      endcase
    end
  end

endmodule

// File: tb/tb_tictac_referee.sv
// Directed bench for tictac_referee: a 3x3 instance covers the general rules
// and a 4x4 instance covers the larger-board line detection.
module tb_tictac_referee;

  logic        clock = 1'b0;
  logic        reset = 1'b0;

  logic        newGame3 = 1'b0;
  logic [3:0]  move3 = '0;
  logic        moveValid3 = 1'b0;
  logic        moveReady3;
  logic [1:0]  turn3;
  logic [17:0] board3;
  logic [3:0]  moveCount3;
  logic        illegal3, win3, draw3;
  logic [1:0]  winner3;

  logic        newGame4 = 1'b0;
  logic [3:0]  move4 = '0;
  logic        moveValid4 = 1'b0;
  logic        moveReady4;
  logic [1:0]  turn4;
  logic [31:0] board4;
  logic [4:0]  moveCount4;
  logic        illegal4, win4, draw4;
  logic [1:0]  winner4;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  tictac_referee #(.N(3), .FIRST(2'b01)) dut3 (
    .clock(clock), .reset(reset), .newGame(newGame3), .move(move3),
    .moveValid(moveValid3), .moveReady(moveReady3), .turn(turn3),
    .board(board3), .moveCount(moveCount3), .illegal(illegal3),
    .win(win3), .winner(winner3), .draw(draw3)
  );

  tictac_referee #(.N(4), .FIRST(2'b01)) dut4 (
    .clock(clock), .reset(reset), .newGame(newGame4), .move(move4),
    .moveValid(moveValid4), .moveReady(moveReady4), .turn(turn4),
    .board(board4), .moveCount(moveCount4), .illegal(illegal4),
    .win(win4), .winner(winner4), .draw(draw4)
  );

  // Offer one move at a negedge; returns at the negedge after the CHECK cycle.
  task automatic applyMove3(input int m);
    move3 = 4'(m);
    moveValid3 = 1'b1;
    @(negedge clock);
    moveValid3 = 1'b0;
    @(negedge clock);
  endtask

  task automatic applyMove4(input int m);
    move4 = 4'(m);
    moveValid4 = 1'b1;
    @(negedge clock);
    moveValid4 = 1'b0;
    @(negedge clock);
  endtask

  task automatic restart3();
    newGame3 = 1'b1;
    @(negedge clock);
    newGame3 = 1'b0;
  endtask

  task automatic restart4();
    newGame4 = 1'b1;
    @(negedge clock);
    newGame4 = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1;
    #1;
    total++; if (moveReady3 !== 1'b0) begin bad++; $display("[TB] FAIL ready_in_reset: got %0b want 0", moveReady3); end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    total++; if (board3 !== 18'h0) begin bad++; $display("[TB] FAIL reset_board: got %0h want 0", board3); end
    total++; if (moveCount3 !== 4'd0) begin bad++; $display("[TB] FAIL reset_count: got %0d want 0", moveCount3); end
    total++; if (turn3 !== 2'b01) begin bad++; $display("[TB] FAIL reset_turn: got %0b want 01", turn3); end
    total++; if ({illegal3, win3, winner3, draw3} !== 5'b0) begin bad++; $display("[TB] FAIL reset_flags: got %0b want 0", {illegal3, win3, winner3, draw3}); end
    total++; if (moveReady3 !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready: got %0b want 1", moveReady3); end
  endtask

  task automatic test_row_win();
    restart3();
    move3 = 4'd0;
    moveValid3 = 1'b1;
    @(negedge clock);
    moveValid3 = 1'b0;
    total++; if (moveReady3 !== 1'b0) begin bad++; $display("[TB] FAIL ready_in_check: got %0b want 0", moveReady3); end
    @(negedge clock);
    total++; if (moveReady3 !== 1'b1 || turn3 !== 2'b10) begin bad++; $display("[TB] FAIL after_first_move: ready %0b turn %0b want 1 10", moveReady3, turn3); end
    applyMove3(3);
    applyMove3(1);
    applyMove3(4);
    applyMove3(2);
    total++; if (win3 !== 1'b1 || winner3 !== 2'b01) begin bad++; $display("[TB] FAIL row_win: win %0b winner %0b want 1 01", win3, winner3); end
    total++; if (moveCount3 !== 4'd5 || moveReady3 !== 1'b0 || draw3 !== 1'b0) begin bad++; $display("[TB] FAIL row_win_state: count %0d ready %0b draw %0b want 5 0 0", moveCount3, moveReady3, draw3); end
    total++; if (board3 !== 18'h295) begin bad++; $display("[TB] FAIL row_win_board: got %0h want 295", board3); end
    // Moves offered after the game ends are silently ignored.
    move3 = 4'd5;
    moveValid3 = 1'b1;
    @(negedge clock);
    moveValid3 = 1'b0;
    total++; if (illegal3 !== 1'b0 || moveCount3 !== 4'd5 || win3 !== 1'b1) begin bad++; $display("[TB] FAIL over_ignores: illegal %0b count %0d win %0b want 0 5 1", illegal3, moveCount3, win3); end
  endtask

  task automatic test_illegal();
    restart3();
    applyMove3(4);
    move3 = 4'd4;
    moveValid3 = 1'b1;
    @(negedge clock);
    moveValid3 = 1'b0;
    total++; if (illegal3 !== 1'b1) begin bad++; $display("[TB] FAIL occupied_illegal: got %0b want 1", illegal3); end
    total++; if (turn3 !== 2'b10 || moveCount3 !== 4'd1 || board3 !== 18'h100) begin bad++; $display("[TB] FAIL occupied_state: turn %0b count %0d board %0h want 10 1 100", turn3, moveCount3, board3); end
    @(negedge clock);
    total++; if (illegal3 !== 1'b0 || moveReady3 !== 1'b1) begin bad++; $display("[TB] FAIL illegal_pulse: illegal %0b ready %0b want 0 1", illegal3, moveReady3); end
    move3 = 4'd9;
    moveValid3 = 1'b1;
    @(negedge clock);
    moveValid3 = 1'b0;
    total++; if (illegal3 !== 1'b1 || moveCount3 !== 4'd1) begin bad++; $display("[TB] FAIL range_illegal: illegal %0b count %0d want 1 1", illegal3, moveCount3); end
    @(negedge clock);
  endtask

  task automatic test_draw();
    int seq[9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    restart3();
    foreach (seq[i]) applyMove3(seq[i]);
    total++; if (draw3 !== 1'b1 || win3 !== 1'b0 || winner3 !== 2'b00) begin bad++; $display("[TB] FAIL draw: draw %0b win %0b winner %0b want 1 0 00", draw3, win3, winner3); end
    total++; if (moveCount3 !== 4'd9 || moveReady3 !== 1'b0) begin bad++; $display("[TB] FAIL draw_state: count %0d ready %0b want 9 0", moveCount3, moveReady3); end
  endtask

  task automatic test_full_board_win();
    int seq[9] = '{0, 1, 2, 4, 3, 5, 7, 8, 6};
    restart3();
    foreach (seq[i]) applyMove3(seq[i]);
    total++; if (win3 !== 1'b1 || draw3 !== 1'b0 || winner3 !== 2'b01) begin bad++; $display("[TB] FAIL ninth_win: win %0b draw %0b winner %0b want 1 0 01", win3, draw3, winner3); end
    total++; if (moveCount3 !== 4'd9) begin bad++; $display("[TB] FAIL ninth_count: got %0d want 9", moveCount3); end
  endtask

  task automatic test_new_game();
    // Previous task left the game in OVER.
    restart3();
    #1;
    total++; if (moveReady3 !== 1'b1 || win3 !== 1'b0 || board3 !== 18'h0) begin bad++; $display("[TB] FAIL newgame_over: ready %0b win %0b board %0h want 1 0 0", moveReady3, win3, board3); end
    applyMove3(4);
    newGame3 = 1'b1;
    move3 = 4'd0;
    moveValid3 = 1'b1;
    #1;
    total++; if (moveReady3 !== 1'b0) begin bad++; $display("[TB] FAIL ready_during_newgame: got %0b want 0", moveReady3); end
    @(negedge clock);
    newGame3 = 1'b0;
    moveValid3 = 1'b0;
    total++; if (board3 !== 18'h0 || illegal3 !== 1'b0 || turn3 !== 2'b01 || moveCount3 !== 4'd0) begin bad++; $display("[TB] FAIL newgame_priority: board %0h illegal %0b turn %0b count %0d want 0 0 01 0", board3, illegal3, turn3, moveCount3); end
    @(negedge clock);
    total++; if (board3 !== 18'h0 || moveCount3 !== 4'd0) begin bad++; $display("[TB] FAIL newgame_move_lost: board %0h count %0d want 0 0", board3, moveCount3); end
  endtask

  task automatic test_reset_in_check();
    restart3();
    applyMove3(0);
    move3 = 4'd4;
    moveValid3 = 1'b1;
    @(negedge clock);
    moveValid3 = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    total++; if (board3 !== 18'h0 || moveCount3 !== 4'd0 || turn3 !== 2'b01) begin bad++; $display("[TB] FAIL reset_check_state: board %0h count %0d turn %0b want 0 0 01", board3, moveCount3, turn3); end
    total++; if ({illegal3, win3, winner3, draw3} !== 5'b0 || moveReady3 !== 1'b1) begin bad++; $display("[TB] FAIL reset_check_flags: flags %0b ready %0b want 0 1", {illegal3, win3, winner3, draw3}, moveReady3); end
  endtask

  task automatic test_n4_lines();
    int antiSeq[8] = '{0, 3, 1, 6, 2, 9, 5, 12};
    int colSeq[7] = '{1, 0, 5, 2, 9, 3, 13};
    restart4();
    foreach (antiSeq[i]) applyMove4(antiSeq[i]);
    total++; if (win4 !== 1'b1 || winner4 !== 2'b10 || draw4 !== 1'b0) begin bad++; $display("[TB] FAIL n4_anti_diag: win %0b winner %0b draw %0b want 1 10 0", win4, winner4, draw4); end
    total++; if (board4 !== 32'h0208_2495 || moveCount4 !== 5'd8) begin bad++; $display("[TB] FAIL n4_anti_board: board %0h count %0d want 2082495 8", board4, moveCount4); end
    restart4();
    foreach (colSeq[i]) begin
      if (i == 5) begin
        total++; if (win4 !== 1'b0 || moveReady4 !== 1'b1) begin bad++; $display("[TB] FAIL n4_no_early_win: win %0b ready %0b want 0 1", win4, moveReady4); end
      end
      applyMove4(colSeq[i]);
    end
    total++; if (win4 !== 1'b1 || winner4 !== 2'b01 || moveCount4 !== 5'd7) begin bad++; $display("[TB] FAIL n4_column: win %0b winner %0b count %0d want 1 01 7", win4, winner4, moveCount4); end
  endtask

  initial begin
    test_reset();
    test_row_win();
    test_illegal();
    test_draw();
    test_full_board_win();
    test_new_game();
    test_reset_in_check();
    test_n4_lines();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tictac_referee.md
TICTAC_REFEREE -- requirements
Module: tictac_referee

Interface
REQ-001 The block SHALL have parameter N, default 3, board side length (legal 3..8).
REQ-002 The block SHALL have parameter FIRST, default 2'b01, cell code of the player moving first after reset/newGame (2'b01=X, 2'b10=O).
REQ-003 Port: clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: newGame  input  1  clear board and restart; sampled every cycle.
REQ-006 Port: move  input  IW=$clog2(N*N)  cell index, row-major (row*N+col).
REQ-007 Port: moveValid  input  1  move offered this cycle.
REQ-008 Port: moveReady  output  1  block accepts a move this cycle.
REQ-009 Port: turn  output  2  cell code of player to move.
REQ-010 Port: board  output  2*N*N  cell i at bits [2i+1:2i]; 00 empty, 01 X, 10 O.
REQ-011 Port: moveCount  output  $clog2(N*N+1)  number of accepted moves this game.
REQ-012 Port: illegal  output  1  one-cycle pulse: rejected move.
REQ-013 Port: win  output  1  game ended with a completed line.
REQ-014 Port: winner  output  2  cell code of winner; 00 when win=0.
REQ-015 Port: draw  output  1  board full, no line.

Function
REQ-016 The FSM SHALL have states PLAY, CHECK, OVER.
REQ-017 moveReady SHALL be 1 exactly when state=PLAY and newGame=0.
REQ-018 A move SHALL be accepted on a cycle with moveValid=1 and moveReady=1 if move<N*N and that cell is 00.
- accepted: cell <= turn, moveCount+1, state -> CHECK.
REQ-019 A move offered with moveValid=1 and moveReady=1 that is out of range or targets an occupied cell SHALL be rejected.
- illegal=1 on the following cycle only.
- board, turn, moveCount and state unchanged.
REQ-020 In CHECK (exactly one cycle) the block SHALL test all N rows, N columns and both diagonals for N cells equal to the last mover's code.
REQ-021 CHECK outcomes SHALL be, in priority order:
- line found -> OVER, win=1, winner=mover.
- else moveCount==N*N -> OVER, draw=1.
- else -> PLAY, turn toggles (01<->10).
REQ-022 Accept-to-next-moveReady latency SHALL be 2 cycles; maximum throughput one move per 2 cycles.
REQ-023 In OVER, moveReady=0, moveValid SHALL be ignored (no illegal pulse), and outputs SHALL hold until newGame or reset.
REQ-024 newGame=1 in any state SHALL on the next edge:
- clear board to 0 and moveCount to 0.
- set turn=FIRST, state=PLAY.
- clear win, winner, draw, illegal.
REQ-025 newGame SHALL take priority over a simultaneous moveValid; that move is neither accepted nor flagged.
REQ-026 win and draw SHALL never both be 1.
REQ-027 A final move that both fills the board and completes a line SHALL report win, not draw.

Reset
REQ-028 reset=1 SHALL on the next rising edge force:
- state=PLAY, board=0, moveCount=0, turn=FIRST.
- illegal=0, win=0, winner=00, draw=0.
REQ-029 reset SHALL take priority over newGame and moves, including mid-CHECK.
REQ-030 moveReady SHALL be 0 while reset=1.

Structure
REQ-031 Package tictac_pkg SHALL hold:
- cell code typedef (EMPTY=2'b00, X=2'b01, O=2'b10).
- FSM state enum.
- function returning the opponent code.
REQ-032 Line detection SHALL be a combinational sub-module tictac_line_check (parameter N; inputs board, player; output found), instantiated once.

Verification
REQ-033 N=3, reset, X plays 0, O 3, X 1, O 4, X 2 -> win=1, winner=01 two cycles after the fifth accept, moveCount=5, moveReady=0.
REQ-034 N=3, X plays 4, then O plays 4 -> illegal pulses for 1 cycle, turn stays 10, moveCount=1; then move=9 -> illegal again.
REQ-035 N=3, sequence 0,1,2,4,3,5,7,6,8 -> draw=1, win=0, moveCount=9; a sequence whose ninth move completes a line -> win=1, draw=0.
REQ-036 N=4, anti-diagonal O win (cells 3,6,9,12 for O, other cells for X) -> winner=10; check column 1 X win separately.
REQ-037 newGame and moveValid asserted together in PLAY -> board=0, no illegal, turn=FIRST next cycle; newGame in OVER -> moveReady=1 next cycle.
REQ-038 reset asserted during CHECK -> next cycle all outputs at reset values and the pending move lost.
